mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of mux input channels scanned; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter DWELL, default 4, meaning clock cycles spent on each channel; legal values are 2 to 255.
REQ-003 The block SHALL have local constant SW = log2(N_CH), the select width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: request one scan; sampled only in IDLE.
REQ-007 The block SHALL have port sel, output, SW bits: channel select driven to the downstream mux select input.
REQ-008 The block SHALL have port y, input, 1 bit: the mux output fed back for sampling.
REQ-009 The block SHALL have port frame, output, N_CH bits: captured channel values; bit k is the value of channel k.
REQ-010 The block SHALL have port frame_valid, output, 1 bit: frame holds a complete scan.
REQ-011 The block SHALL have port frame_ready, input, 1 bit: consumer accepts frame.
REQ-012 The block SHALL have port busy, output, 1 bit: high in SCAN and OUT states.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, SCAN and OUT, with reset state IDLE.
REQ-014 In IDLE with start=1 at an edge, the block SHALL enter SCAN with ch=0, dwell counter cnt=0, sel=0 and busy=1.
REQ-015 In SCAN, sel SHALL equal ch, and cnt SHALL increment each cycle.
REQ-016 At the edge where cnt==DWELL-1, the block SHALL set frame[ch] to y and clear cnt to 0.
REQ-017 At that same edge, if ch<N_CH-1 the block SHALL increment ch; otherwise it SHALL enter OUT.
REQ-018 The cycles with cnt<DWELL-1 SHALL serve as mux settling time; y SHALL be ignored during them.
REQ-019 frame_valid SHALL rise exactly N_CH*DWELL edges after the start edge (16 for the defaults) and SHALL be registered.
REQ-020 In OUT, frame_valid=1 and frame SHALL stay stable until an edge with frame_ready=1.
REQ-021 At the OUT edge with frame_ready=1, frame_valid SHALL clear and the block SHALL go to IDLE, unless the configured behaviour of REQ-029 applies.
REQ-022 frame_ready asserted outside OUT SHALL have no effect.
REQ-023 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 At an OUT edge where frame_ready=1 and start=1 coincide, the block SHALL go to IDLE; start SHALL take effect only from the next cycle.
REQ-025 In IDLE and OUT, sel SHALL hold its last value, which is N_CH-1 after a scan.
REQ-026 frame SHALL retain its previous contents between scans; bits SHALL be overwritten one by one during a scan.

Reset
REQ-027 While rst_n=0, regardless of clk, the block SHALL force state IDLE, ch=0, cnt=0, sel=0, frame=0, frame_valid=0 and busy=0.
REQ-028 If reset asserts during SCAN or OUT, the block SHALL abort the scan, discard any partial frame, and resume in IDLE at the first edge after rst_n goes high; no frame_valid pulse SHALL result from the aborted scan.

Configuration
REQ-029 With macro MUX_SCAN_CONT_EN defined, the OUT handshake edge SHALL go directly to SCAN with ch=0 and cnt=0, busy SHALL remain 1, and start SHALL be needed only for the first scan.
REQ-030 Without MUX_SCAN_CONT_EN, the block SHALL return to IDLE after every accepted frame, and each scan SHALL require a new start.

Structure
REQ-031 The shared package mux_pkg SHALL hold the FSM state enum (IDLE/SCAN/OUT) and the default N_CH and DWELL constants.
REQ-032 One sub-module, mux_dwell_cnt, SHALL implement the parameterised dwell counter with a clear input and a terminal-count output; all other logic SHALL be inline.

Verification
REQ-033 Defaults, channel values {ch3..ch0}=1010, start pulse -> sel steps 0,1,2,3 every 4 cycles; frame_valid rises 16 edges after start; frame=4'b1010.
REQ-034 frame_ready held 0 for 10 cycles in OUT -> frame_valid and frame stay stable; on frame_ready=1, frame_valid drops at the next edge and state is IDLE.
REQ-035 start pulsed again at cycle 5 of a scan -> no effect, and exactly one frame is produced.
REQ-036 rst_n pulsed low at cycle 9 of a scan -> all outputs 0 immediately (asynchronous); no frame_valid is produced afterwards without a new start.
REQ-037 N_CH=2, DWELL=2, y toggled during settle cycles only -> frame reflects y only at the cnt==1 sample edges; frame_valid 4 edges after start.
REQ-038 MUX_SCAN_CONT_EN defined, frame_ready tied to 1 -> back-to-back frames every 17 cycles (16 scan + 1 OUT), with busy constantly 1.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and default sizing for the mux scan controller.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int MUX_N_CH_DEF  = 4;
  localparam int MUX_DWELL_DEF = 4;

endpackage

// File: rtl/mux_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the terminal count.
module mux_dwell_cnt #(
  parameter int DWELL = 4,
  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CW'(DWELL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps an external mux through N_CH channels, samples y after DWELL-1 settle
// cycles per channel and hands off the frame. MUX_SCAN_CONT_EN: free-running scans.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int N_CH  = MUX_N_CH_DEF,
  parameter int DWELL = MUX_DWELL_DEF,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [SW-1:0]   sel,
  input  logic            y,
  output logic [N_CH-1:0] frame,
  output logic            frame_valid,
  input  logic            frame_ready,
  output logic            busy
);

  state_e          state_q;
  logic [SW-1:0]   ch_q;
  logic [N_CH-1:0] frame_q;
  logic            fv_q;
  logic            busy_q;
  logic            tc;

  // Counter is held at zero outside SCAN so every channel gets a full dwell.
  mux_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q == SCAN),
    .clr_i (state_q != SCAN),
    .tc_o  (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      frame_q <= '0;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            ch_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (tc) begin
            frame_q[ch_q] <= y;
            if (ch_q == SW'(N_CH - 1)) begin
              state_q <= OUT;
              fv_q    <= 1'b1;
            end else begin
              ch_q <= ch_q + SW'(1);
            end
          end
        end
        OUT: begin
          if (frame_ready) begin
            fv_q <= 1'b0;
`ifdef MUX_SCAN_CONT_EN
            state_q <= SCAN;
            ch_q    <= '0;
`else
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          fv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign sel         = ch_q;
  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: default instance plus a 2-channel/2-dwell instance.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] sel;
  logic       y;
  logic [3:0] frame;
  logic       fv;
  logic       busy;
  logic [3:0] chv = 4'b1010;

  logic       start2 = 1'b0;
  logic       ready2 = 1'b0;
  logic       sel2;
  logic       y2 = 1'b0;
  logic [1:0] frame2;
  logic       fv2;
  logic       busy2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign y = chv[sel];

  mux_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .y(y),
    .frame(frame), .frame_valid(fv), .frame_ready(ready), .busy(busy)
  );

  mux_scan_ctrl #(.N_CH(2), .DWELL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sel(sel2), .y(y2),
    .frame(frame2), .frame_valid(fv2), .frame_ready(ready2), .busy(busy2)
  );

  typedef struct {
    logic       st;
    logic       rdy;
    logic [1:0] sel;
    logic       fv;
    logic       bsy;
    logic [3:0] frm;
  } vec_t;

  vec_t tv [18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef MUX_SCAN_CONT_EN
  localparam logic [3:0] RST_F4 = 4'b0001;
  localparam logic [3:0] RST_F8 = 4'b0001;
`else
  localparam logic [3:0] RST_F4 = 4'b1011;
  localparam logic [3:0] RST_F8 = 4'b1001;
`endif

  initial begin
    // row k = state after the k-th edge counted from the start edge
    tv[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'h0};
    tv[1]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'h0};
    tv[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'h0};
    tv[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'h0};
    tv[4]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 4'h0};
    tv[5]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 4'h0};
    tv[6]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 4'h0};
    tv[7]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 4'h0};
    tv[8]  = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 4'h2};
    tv[9]  = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 4'h2};
    tv[10] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 4'h2};
    tv[11] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 4'h2};
    tv[12] = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 4'h2};
    tv[13] = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 4'h2};
    tv[14] = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 4'h2};
    tv[15] = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 4'h2};
    tv[16] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 4'hA};
    tv[17] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 4'hA};

    #12;
    chk("rst_sel",   32'(sel),   32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_fv",    32'(fv),    32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Main scan; row 5 also re-pulses start and frame_ready mid-scan.
    for (int k = 0; k < 18; k++) begin
      start = tv[k].st;
      ready = tv[k].rdy;
      step();
      chk($sformatf("v%0d_sel", k),   32'(sel),   32'(tv[k].sel));
      chk($sformatf("v%0d_fv", k),    32'(fv),    32'(tv[k].fv));
      chk($sformatf("v%0d_busy", k),  32'(busy),  32'(tv[k].bsy));
      chk($sformatf("v%0d_frame", k), 32'(frame), 32'(tv[k].frm));
    end
    start = 1'b0;
    ready = 1'b0;

    // OUT held without handshake; channel inputs change but frame must not.
    chv = 4'b0101;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("hold_fv",    32'(fv),    32'd1);
      chk("hold_frame", 32'(frame), 32'hA);
    end
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    ready = 1'b0;
    chk("hs_fv", 32'(fv), 32'd0);
`ifdef MUX_SCAN_CONT_EN
    chk("hs_busy", 32'(busy), 32'd1);
    chk("hs_sel",  32'(sel),  32'd0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
`else
    chk("hs_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_busy",  32'(busy),  32'd0);
      chk("idle_frame", 32'(frame), 32'hA);
      chk("idle_sel",   32'(sel),   32'd3);
    end
`endif

    // Asynchronous reset mid-scan, chv = 0101
    start = 1'b1;
    step();
    start = 1'b0;
    chk("r_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 4) chk("r_f4", 32'(frame), 32'(RST_F4));
      if (k == 8) chk("r_f8", 32'(frame), 32'(RST_F8));
    end
    chk("r_sel9", 32'(sel), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_sel",   32'(sel),   32'd0);
    chk("ar_frame", 32'(frame), 32'd0);
    chk("ar_fv",    32'(fv),    32'd0);
    chk("ar_busy",  32'(busy),  32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic saw;
      saw = 1'b0;
      ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
        step();
        if (fv || busy) saw = 1'b1;
      end
      ready = 1'b0;
      chk("post_rst_quiet", 32'(saw), 32'd0);
    end

`ifdef MUX_SCAN_CONT_EN
    begin
      int  rise1, rise2;
      logic prev, bsy_all;
      rise1 = -1; rise2 = -1; prev = 1'b0; bsy_all = 1'b1;
      ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        step();
        if (!busy) bsy_all = 1'b0;
        if (fv && !prev) begin
          if (rise1 < 0) rise1 = k;
          else if (rise2 < 0) rise2 = k;
        end
        prev = fv;
      end
      chk("cont_rise1", 32'(rise1), 32'd16);
      chk("cont_rise2", 32'(rise2), 32'd33);
      chk("cont_busy",  32'(bsy_all), 32'd1);
      ready = 1'b0;
    end
`else
    // Fresh scan, chv = 0110: frame rebuilt, latency rechecked
    chv = 4'b0110;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) chk("s2_fv15", 32'(fv), 32'd0);
    end
    chk("s2_fv16",  32'(fv),    32'd1);
    chk("s2_frame", 32'(frame), 32'h6);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("s2_idle", 32'(busy), 32'd0);
`endif

    // N_CH=2, DWELL=2: y differs between settle and sample edges
    start2 = 1'b1;
    y2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("d2_busy", 32'(busy2), 32'd1);
    y2 = 1'b1; step();
    y2 = 1'b0; step();
    chk("d2_sel2", 32'(sel2),   32'd1);
    chk("d2_f2",   32'(frame2), 32'd0);
    y2 = 1'b0; step();
    chk("d2_fv3",  32'(fv2),    32'd0);
    y2 = 1'b1; step();
    chk("d2_fv4",  32'(fv2),    32'd1);
    chk("d2_frame", 32'(frame2), 32'd2);
    y2 = 1'b0;
    ready2 = 1'b1;
    step();
    ready2 = 1'b0;
    chk("d2_hs_fv", 32'(fv2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
